vchip_alu_sequencer: RTL and testbench

Bus-master front end for the verichip ALU register block. Accepts one ALU operation per request over a valid/ready handshake, writes the operand and command registers on the chip register bus, reads back status and the ALU result, and returns both on a response handshake. Sits directly upstream of the verichip register interface: its bus outputs drive the chip's `chip_select`, `address`, `byte_en`, `rw_` and `data_in`, and its `rd_data` input is the chip's `data_out`.

---
 rtl/vchip_alu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_vchip_alu_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vchip_alu_sequencer.sv
// vchip_alu_sequencer
//   Bus master in front of the verichip ALU register block. For each request
//   it writes the operands and the command, lets the chip execute for one
//   cycle, reads back status and the ALU result, and returns them on a
//   response handshake.
//
//   Optional build macro: VCHIP_SEQ_INT_CLR_EN. When defined, any interrupt
//   bit seen in the status read is cleared on the chip before the response.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake; req_op, req_keep, req_left, req_right
//   rsp_valid/rsp_ready   : response handshake; rsp_result, rsp_state, rsp_int, rsp_err
//   chip_select, address, byte_en, rw_ (1 = read), wr_data : chip register bus
//   rd_data               : combinational read data from the chip
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// WR_LFT  | writing left operand (0x10)
// WR_RGT  | writing right operand (0x14)
// WR_CMD  | writing command with valid bit (0x08)
// WAIT    | bus idle while the chip executes
// RD_STA  | reading status (0x04)
// CLR_INT | clearing int2/int1 in status (macro builds only)
// RD_ALU  | reading ALU result (0x18)
// RESP    | response held until rsp_ready
module vchip_alu_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic              req_keep,
  input  logic [DATA_W-1:0] req_left,
  input  logic [DATA_W-1:0] req_right,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_state,
  output logic [1:0]        rsp_int,
  output logic              rsp_err,
  output logic              chip_select,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        byte_en,
  output logic              rw_,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] A_STA = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_LFT = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_RGT = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_ALU = ADDR_W'(8'h18);

  typedef enum logic [3:0] {
    IDLE,
    WR_LFT,
    WR_RGT,
    WR_CMD,
    WAIT,
    RD_STA,
`ifdef VCHIP_SEQ_INT_CLR_EN
    CLR_INT,
`endif
    RD_ALU,
    RESP
  } state_t;

  state_t            state, nxt;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] left_q, right_q;
  logic [3:0]        op_src;
  logic [DATA_W-1:0] left_src;

  assign req_ready = (state == IDLE) && !rst;

  // Bus outputs are loaded from the next state, so on the accept edge the
  // request fields are not yet in the holding registers; use them directly.
  assign op_src   = (state == IDLE) ? req_op   : op_q;
  assign left_src = (state == IDLE) ? req_left : left_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = req_keep ? WR_CMD : WR_LFT;
      WR_LFT:  nxt = WR_RGT;
      WR_RGT:  nxt = WR_CMD;
      WR_CMD:  nxt = WAIT;
      WAIT:    nxt = RD_STA;
`ifdef VCHIP_SEQ_INT_CLR_EN
      RD_STA:  nxt = (rd_data[9:8] != 2'b00) ? CLR_INT : RD_ALU;
      CLR_INT: nxt = RD_ALU;
`else
      RD_STA:  nxt = RD_ALU;
`endif
      RD_ALU:  nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      left_q      <= '0;
      right_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_state   <= '0;
      rsp_int     <= '0;
      rsp_err     <= 1'b0;
      chip_select <= 1'b0;
      address     <= '0;
      byte_en     <= 2'b00;
      rw_         <= 1'b1;
      wr_data     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        left_q  <= req_left;
        right_q <= req_right;
      end
      if (state == RD_STA) begin
        rsp_state <= rd_data[3:0];
        rsp_int   <= rd_data[9:8];
        rsp_err   <= (rd_data[3:0] != 4'h1);
      end
      if (state == RD_ALU) rsp_result <= rd_data;
      rsp_valid <= (nxt == RESP);

      chip_select <= 1'b0;
      address     <= '0;
      byte_en     <= 2'b00;
      rw_         <= 1'b1;
      wr_data     <= '0;
      case (nxt)
        WR_LFT: begin
          chip_select <= 1'b1; address <= A_LFT; byte_en <= 2'b11; rw_ <= 1'b0;
          wr_data     <= left_src;
        end
        WR_RGT: begin
          chip_select <= 1'b1; address <= A_RGT; byte_en <= 2'b11; rw_ <= 1'b0;
          wr_data     <= right_q;
        end
        WR_CMD: begin
          chip_select <= 1'b1; address <= A_CMD; byte_en <= 2'b11; rw_ <= 1'b0;
          wr_data     <= {1'b1, {(DATA_W-5){1'b0}}, op_src};
        end
        RD_STA: begin
          chip_select <= 1'b1; address <= A_STA;
        end
`ifdef VCHIP_SEQ_INT_CLR_EN
        CLR_INT: begin
          // Write-one-to-clear on int2/int1, upper byte lane only.
          chip_select <= 1'b1; address <= A_STA; byte_en <= 2'b10; rw_ <= 1'b0;
          wr_data     <= DATA_W'(16'h0300);
        end
`endif
        RD_ALU: begin
          chip_select <= 1'b1; address <= A_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vchip_alu_sequencer.sv
module tb_vchip_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic        req_keep = 1'b0;
  logic [15:0] req_left = 16'h0, req_right = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_state;
  logic [1:0]  rsp_int;
  logic        rsp_err;
  logic        chip_select;
  logic [6:0]  address;
  logic [1:0]  byte_en;
  logic        rw_;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  vchip_alu_sequencer #(.ADDR_W(7), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_keep(req_keep),
    .req_left(req_left), .req_right(req_right),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_state(rsp_state), .rsp_int(rsp_int), .rsp_err(rsp_err),
    .chip_select(chip_select), .address(address), .byte_en(byte_en), .rw_(rw_),
    .wr_data(wr_data), .rd_data(rd_data)
  );

  // Small behavioural model of the chip register block.
  logic [15:0] c_lft = 16'h0, c_rgt = 16'h0, c_alu = 16'h0, c_sum;
  logic [3:0]  c_state = 4'h1;
  logic        c_int1 = 1'b0, c_int2 = 1'b0;
  logic        c_int1_en = 1'b0, c_exp_dis = 1'b0;

  always_comb begin
    rd_data = 16'h0;
    if (chip_select && rw_) begin
      case (address)
        7'h04: rd_data = {6'h0, c_int2, c_int1, 4'h0, c_state};
        7'h10: rd_data = c_lft;
        7'h14: rd_data = c_rgt;
        7'h18: rd_data = c_alu;
        default: rd_data = 16'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (chip_select && !rw_) begin
      case (address)
        7'h10: c_lft <= wr_data;
        7'h14: c_rgt <= wr_data;
        7'h04: if (byte_en[1]) begin
          if (wr_data[9]) c_int2 <= 1'b0;
          if (wr_data[8]) c_int1 <= 1'b0;
        end
        7'h08: if (wr_data[15]) begin
          if (c_exp_dis) begin
            c_state <= 4'h8; c_alu <= 16'h0;
          end else begin
            case (wr_data[3:0])
              4'd1: begin
                c_sum = c_lft + c_rgt;
                if (c_lft[15] == c_rgt[15] && c_sum[15] != c_lft[15]) begin
                  c_state <= 4'h2;
                  if (c_int1_en) c_int1 <= 1'b1;
                end else begin
                  c_alu <= c_sum; c_state <= 4'h1;
                end
              end
              4'd3: begin c_lft <= c_alu; c_state <= 4'h1; end
              4'd6: begin c_alu <= {c_lft[14:0], 1'b0}; c_state <= 4'h1; end
              default: c_state <= (wr_data[3:0] > 4'd7) ? 4'h2 : 4'h1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Bus log for the current operation, cycle numbers relative to accept edge.
  int          cyc = 0, c0 = 0, tr_n = 0, lat = 0;
  logic [6:0]  tr_addr [16];
  logic        tr_rw   [16];
  logic [15:0] tr_data [16];
  logic [1:0]  tr_be   [16];
  int          tr_rel  [16];

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (chip_select && tr_n < 16) begin
      tr_addr[tr_n] = address; tr_rw[tr_n] = rw_; tr_data[tr_n] = wr_data;
      tr_be[tr_n] = byte_en; tr_rel[tr_n] = cyc - c0; tr_n++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and run until rsp_valid (bounded); leaves response pending.
  task automatic run_op(input logic [3:0] op, input logic keep, input logic [15:0] l, input logic [15:0] r);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    check("req_ready_before_op", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = op; req_keep = keep; req_left = l; req_right = r;
    tr_n = 0; c0 = cyc;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("req_ready_after_handshake", {31'h0, req_ready}, 32'h1);
    check("rsp_valid_after_handshake", {31'h0, rsp_valid}, 32'h0);
  endtask

`ifdef VCHIP_SEQ_INT_CLR_EN
  localparam logic [1:0] PEND_INT = 2'b00;
`else
  localparam logic [1:0] PEND_INT = 2'b01;
`endif

  initial begin
    logic [6:0] ea [5];
    int         ec [5];
    logic       bad;
    logic [15:0] held;

    // Reset
    tick(); tick();
    check("reset_req_ready", {31'h0, req_ready}, 32'h0);
    check("reset_rsp", {11'h0, rsp_valid, rsp_result, rsp_state, rsp_int, rsp_err}, 32'h0);
    check("reset_bus", {chip_select, address, byte_en, rw_, wr_data}, {1'b0, 7'h0, 2'b00, 1'b1, 16'h0});
    rst = 1'b0;
    tick();
    check("req_ready_after_reset", {31'h0, req_ready}, 32'h1);

    // ADD 3 + 4, chip in NORM
    run_op(4'd1, 1'b0, 16'h0003, 16'h0004);
    check("add_latency", lat, 7);
    check("add_result", {16'h0, rsp_result}, 32'h0007);
    check("add_state", {28'h0, rsp_state}, 32'h1);
    check("add_err", {31'h0, rsp_err}, 32'h0);
    check("add_int", {30'h0, rsp_int}, 32'h0);
    check("add_bus_count", tr_n, 5);
    ea[0] = 7'h10; ea[1] = 7'h14; ea[2] = 7'h08; ea[3] = 7'h04; ea[4] = 7'h18;
    ec[0] = 1; ec[1] = 2; ec[2] = 3; ec[3] = 5; ec[4] = 6;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("add_bus_addr%0d", i), {25'h0, tr_addr[i]}, {25'h0, ea[i]});
      check($sformatf("add_bus_cycle%0d", i), tr_rel[i], ec[i]);
      check($sformatf("add_bus_rw%0d", i), {31'h0, tr_rw[i]}, {31'h0, (i >= 3)});
    end
    check("add_wr_left", {16'h0, tr_data[0]}, 32'h0003);
    check("add_wr_right", {16'h0, tr_data[1]}, 32'h0004);
    check("add_wr_cmd", {14'h0, tr_be[2], tr_data[2]}, {14'h0, 2'b11, 16'h8001});
    check("add_rd_sta_idle_data", {14'h0, tr_be[3], tr_data[3]}, 32'h0);
    handshake();

    // ADD overflow with int1 enabled; then hold the response for 3 cycles
    c_int1_en = 1'b1;
    run_op(4'd1, 1'b0, 16'h7FFF, 16'h0001);
`ifdef VCHIP_SEQ_INT_CLR_EN
    check("ovf_latency", lat, 8);
    bad = 1'b1;
    for (int i = 0; i < tr_n; i++)
      if (tr_addr[i] == 7'h04 && !tr_rw[i] && tr_be[i] == 2'b10 && tr_data[i] == 16'h0300) bad = 1'b0;
    check("ovf_clr_int_write", {31'h0, bad}, 32'h0);
    check("ovf_chip_int1_cleared", {31'h0, c_int1}, 32'h0);
`else
    check("ovf_latency", lat, 7);
    check("ovf_bus_count", tr_n, 5);
`endif
    check("ovf_state", {28'h0, rsp_state}, 32'h2);
    check("ovf_err", {31'h0, rsp_err}, 32'h1);
    check("ovf_int", {30'h0, rsp_int}, 32'h1);
    check("ovf_result", {16'h0, rsp_result}, 32'h0007);
    held = rsp_result;
    req_valid = 1'b1; req_op = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_valid%0d", i), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("hold_result%0d", i), {16'h0, rsp_result}, {16'h0, held});
      check($sformatf("hold_ready_bus%0d", i), {30'h0, req_ready, chip_select}, 32'h0);
    end
    req_valid = 1'b0;
    handshake();
    c_int1_en = 1'b0;

    // MVL with keep: no operand writes, shorter latency
    run_op(4'd3, 1'b1, 16'hAAAA, 16'h5555);
    check("mvl_latency", lat, 5);
    check("mvl_bus_count", tr_n, 3);
    bad = 1'b0;
    for (int i = 0; i < tr_n; i++)
      if (tr_addr[i] == 7'h10 || tr_addr[i] == 7'h14) bad = 1'b1;
    check("mvl_no_operand_write", {31'h0, bad}, 32'h0);
    check("mvl_cmd", {16'h0, tr_data[0]}, 32'h8003);
    check("mvl_chip_lft", {16'h0, c_lft}, 32'h0007);
    check("mvl_result", {16'h0, rsp_result}, 32'h0007);
    check("mvl_state_err", {27'h0, rsp_state, rsp_err}, {27'h0, 4'h1, 1'b0});
    check("mvl_int", {30'h0, rsp_int}, {30'h0, PEND_INT});
    handshake();

    // Reset during WR_CMD
    run_op_start: begin
      req_valid = 1'b1; req_op = 4'd1; req_keep = 1'b0; req_left = 16'h0001; req_right = 16'h0002;
      tr_n = 0; c0 = cyc;
      tick();
      req_valid = 1'b0;
      tick(); tick();
    end
    check("rst_in_wr_cmd_addr", {25'h0, address}, 32'h08);
    rst = 1'b1;
    tick();
    check("rst_bus_idle", {chip_select, address, byte_en, rw_, wr_data}, {1'b0, 7'h0, 2'b00, 1'b1, 16'h0});
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid || chip_select) bad = 1'b1;
    end
    check("rst_no_activity", {31'h0, bad}, 32'h0);

    // Export disabled: SHL reports state 8
    c_exp_dis = 1'b1;
    run_op(4'd6, 1'b0, 16'h1234, 16'h0000);
    check("exp_latency", lat, 7);
    check("exp_state", {28'h0, rsp_state}, 32'h8);
    check("exp_err", {31'h0, rsp_err}, 32'h1);
    check("exp_result", {16'h0, rsp_result}, 32'h0000);
    handshake();
    c_exp_dis = 1'b0;

    // Unfiltered op code above 7
    run_op(4'd9, 1'b0, 16'h0010, 16'h0020);
    check("badop_cmd", {16'h0, tr_data[2]}, 32'h8009);
    check("badop_state_err", {27'h0, rsp_state, rsp_err}, {27'h0, 4'h2, 1'b1});
    check("badop_int", {30'h0, rsp_int}, {30'h0, PEND_INT});
    handshake();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
